// File: rtl/bfu_pkg.sv
// Shared types and constants for the ML-DSA butterfly datapath.
package bfu_pkg;

  // Butterfly operation carried with each op down the pipeline
  typedef enum logic [1:0] {
    BFU_NTT  = 2'b00,
    BFU_INTT = 2'b01,
    BFU_SKIP = 2'b10
  } bfu_mode_e;

  localparam int unsigned BFU_Q    = 32'd8380417;
  localparam int unsigned BFU_QINV = 32'd58728449;
  localparam int unsigned BFU_MONT = 32'd4193792;
  localparam int unsigned BFU_LAT  = 5;

  // Both 2'b10 and 2'b11 request a pass-through
  function automatic bfu_mode_e bfu_decode(input logic [1:0] mode);
    bfu_mode_e m;
    case (mode)
      2'b00:   m = BFU_NTT;
      2'b01:   m = BFU_INTT;
      default: m = BFU_SKIP;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mont_reduce.sv
// Two-cycle signed Montgomery reduction: o_r = i_p * 2^-DW mod Q, |o_r| < Q.
// Shared between the butterfly pipeline and the pointwise multiplier.
module mont_reduce
  import bfu_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned Q    = BFU_Q,
  parameter int unsigned QINV = BFU_QINV
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic signed [2*DW-1:0] i_p,
  output logic signed [DW-1:0]   o_r
);

  localparam int unsigned DW2 = 2 * DW;
  localparam logic signed [DW2-1:0] Q_W = DW2'(Q);

  logic [DW-1:0]         m_c;
  logic signed [DW-1:0]  m_q;
  logic signed [DW2-1:0] p_q;
  logic signed [DW2-1:0] mq_c;

  // Quotient estimate from the low word only; product wraps at DW bits
  always_comb begin
    m_c  = i_p[DW-1:0] * DW'(QINV);
    mq_c = DW2'(m_q) * Q_W;
  end

  // First stage holds m with its product, second stage the shifted difference
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      m_q <= '0;
      p_q <= '0;
      o_r <= '0;
    end else if (i_en) begin
      m_q <= m_c;
      p_q <= i_p;
      o_r <= DW'((p_q - mq_c) >>> DW);
    end
  end

endmodule

// File: rtl/bfu_pipe.sv
// Five-stage modular butterfly (CT NTT / GS INTT / skip) with valid/tag
// sideband and global stall. Optional macro BFU_CORRECT_EN canonicalises
// NTT/INTT results into [0,Q) inside the output stage.
module bfu_pipe
  import bfu_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned Q     = BFU_Q,
  parameter int unsigned QINV  = BFU_QINV,
  parameter int unsigned TAG_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_stall,
  input  logic                 i_valid,
  input  logic [1:0]           i_mode,
  input  logic signed [DW-1:0] i_a,
  input  logic signed [DW-1:0] i_b,
  input  logic signed [DW-1:0] i_twiddle,
  input  logic [TAG_W-1:0]     i_tag,
  output logic                 o_valid,
  output logic signed [DW-1:0] o_a,
  output logic signed [DW-1:0] o_b,
  output logic [TAG_W-1:0]     o_tag
);

  localparam int unsigned DW2 = 2 * DW;
`ifdef BFU_CORRECT_EN
  localparam logic signed [DW-1:0] Q_S = DW'(Q);
`endif

  // Bring a result into [0,Q) when the correction build is selected
  function automatic logic signed [DW-1:0] canon(input logic signed [DW-1:0] x);
    logic signed [DW-1:0] y;
    y = x;
`ifdef BFU_CORRECT_EN
    if (y[DW-1]) y = y + Q_S;
    if (y >= Q_S) y = y - Q_S;
`endif
    return y;
  endfunction

  logic                  run_c;
  bfu_mode_e             mode_c;
  logic signed [DW-1:0]  a0_c, b0_c;
  logic signed [DW2-1:0] prod_c;
  logic signed [DW-1:0]  r_c;
  logic signed [DW-1:0]  oa_c, ob_c;

  logic                  s0_v, s1_v, s2_v, s3_v;
  bfu_mode_e             s0_mode, s1_mode, s2_mode, s3_mode;
  logic signed [DW-1:0]  s0_a, s1_a, s2_a, s3_a;
  logic signed [DW-1:0]  s0_b, s1_b, s2_b, s3_b;
  logic [TAG_W-1:0]      s0_tag, s1_tag, s2_tag, s3_tag;
  logic signed [DW-1:0]  s0_tw;
  logic signed [DW2-1:0] s1_p;

  assign run_c = ~i_stall;

  // Input stage: GS butterfly does its add/sub before the multiply
  always_comb begin
    mode_c = bfu_decode(i_mode);
    a0_c   = i_a;
    b0_c   = i_b;
    if (mode_c == BFU_INTT) begin
      a0_c = i_b + i_a;
      b0_c = i_b - i_a;
    end
  end

  // Full-width signed product of b0 and the twiddle
  always_comb begin
    prod_c = DW2'(s0_b) * DW2'(s0_tw);
  end

  // Output stage: combine reduced product with a per mode
  always_comb begin
    oa_c = s3_a;
    ob_c = s3_b;
    case (s3_mode)
      BFU_NTT: begin
        oa_c = canon(s3_a + r_c);
        ob_c = canon(s3_a - r_c);
      end
      BFU_INTT: begin
        oa_c = canon(s3_a);
        ob_c = canon(r_c);
      end
      default: ;
    endcase
  end

  // Pipeline registers S0, S1 and sideband through S3; all freeze on stall
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s0_v <= 1'b0; s0_mode <= BFU_NTT; s0_a <= '0; s0_b <= '0; s0_tw <= '0; s0_tag <= '0;
      s1_v <= 1'b0; s1_mode <= BFU_NTT; s1_a <= '0; s1_b <= '0; s1_p  <= '0; s1_tag <= '0;
      s2_v <= 1'b0; s2_mode <= BFU_NTT; s2_a <= '0; s2_b <= '0; s2_tag <= '0;
      s3_v <= 1'b0; s3_mode <= BFU_NTT; s3_a <= '0; s3_b <= '0; s3_tag <= '0;
    end else if (run_c) begin
      s0_v <= i_valid; s0_mode <= mode_c; s0_a <= a0_c; s0_b <= b0_c;
      s0_tw <= i_twiddle; s0_tag <= i_tag;
      s1_v <= s0_v; s1_mode <= s0_mode; s1_a <= s0_a; s1_b <= s0_b;
      s1_p <= prod_c; s1_tag <= s0_tag;
      s2_v <= s1_v; s2_mode <= s1_mode; s2_a <= s1_a; s2_b <= s1_b; s2_tag <= s1_tag;
      s3_v <= s2_v; s3_mode <= s2_mode; s3_a <= s2_a; s3_b <= s2_b; s3_tag <= s2_tag;
    end
  end

  // Montgomery reduction occupies S2 and S3
  mont_reduce #(
    .DW   (DW),
    .Q    (Q),
    .QINV (QINV)
  ) u_mont (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (run_c),
    .i_p   (s1_p),
    .o_r   (r_c)
  );

  // S4 output register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_a     <= '0;
      o_b     <= '0;
      o_tag   <= '0;
    end else if (run_c) begin
      o_valid <= s3_v;
      o_a     <= oa_c;
      o_b     <= ob_c;
      o_tag   <= s3_tag;
    end
  end

endmodule

// File: tb/tb_bfu_pipe.sv
// Self-checking bench for bfu_pipe: queue-based reference model plus directed literals.
module tb_bfu_pipe;
  import bfu_pkg::*;

  localparam int QS = int'(BFU_Q);

  logic               i_clk;
  logic               i_rst;
  logic               i_stall;
  logic               i_valid;
  logic [1:0]         i_mode;
  logic signed [31:0] i_a, i_b, i_twiddle;
  logic [7:0]         i_tag;
  logic               o_valid;
  logic signed [31:0] o_a, o_b;
  logic [7:0]         o_tag;

  int n_cmp = 0;
  int n_bad = 0;
  int nadv  = 0;

  typedef struct {
    int acc;
    int a;
    int b;
    int tag;
  } exp_t;
  exp_t q[$];

  bfu_pipe dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_stall   (i_stall),
    .i_valid   (i_valid),
    .i_mode    (i_mode),
    .i_a       (i_a),
    .i_b       (i_b),
    .i_twiddle (i_twiddle),
    .i_tag     (i_tag),
    .o_valid   (o_valid),
    .o_a       (o_a),
    .o_b       (o_b),
    .o_tag     (o_tag)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // p * 2^-32 mod Q by the signed Montgomery rule, in plain 64-bit arithmetic
  function automatic int mont(input longint p);
    int unsigned lo;
    int          m;
    longint      d;
    lo = p[31:0];
    m  = int'(lo * BFU_QINV);
    d  = p - longint'(m) * longint'(QS);
    return int'(d >>> 32);
  endfunction

  function automatic int canon(input int x);
    int y;
    y = x;
`ifdef BFU_CORRECT_EN
    if (y < 0) y = y + QS;
    if (y >= QS) y = y - QS;
`endif
    return y;
  endfunction

  function automatic void model(input int mode, input int a, input int b, input int tw,
                                output int oa, output int ob);
    int r;
    if (mode == 0) begin
      r  = mont(longint'(b) * longint'(tw));
      oa = canon(a + r);
      ob = canon(a - r);
    end else if (mode == 1) begin
      r  = mont(longint'(b - a) * longint'(tw));
      oa = canon(b + a);
      ob = canon(r);
    end else begin
      oa = a;
      ob = b;
    end
  endfunction

  // Reference: each accepted op is due once the pipe has advanced LAT-1 more times
  always @(posedge i_clk or posedge i_rst) begin
    exp_t e;
    int   ea, eb;
    if (i_rst) begin
      q.delete();
    end else if (!i_stall) begin
      nadv++;
      if (i_valid) begin
        model(int'(i_mode), int'(i_a), int'(i_b), int'(i_twiddle), ea, eb);
        e.acc = nadv;
        e.a   = ea;
        e.b   = eb;
        e.tag = int'(i_tag);
        q.push_back(e);
      end
    end
  end

  // Per-cycle compare against the reference
  always @(negedge i_clk) begin
    #1;
    if (i_rst) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_a", o_a, 0);
      chk("rst_b", o_b, 0);
      chk("rst_tag", o_tag, 0);
    end else begin
      while (q.size() > 0 && q[0].acc + int'(BFU_LAT) - 1 < nadv) void'(q.pop_front());
      if (q.size() > 0 && q[0].acc + int'(BFU_LAT) - 1 == nadv) begin
        chk("m_valid", o_valid, 1);
        chk("m_a", o_a, q[0].a);
        chk("m_b", o_b, q[0].b);
        chk("m_tag", o_tag, q[0].tag);
      end else begin
        chk("m_idle", o_valid, 0);
      end
    end
  end

  task automatic drive(input int mode, input int a, input int b, input int tw, input int tag);
    i_mode    = 2'(mode);
    i_a       = a;
    i_b       = b;
    i_twiddle = tw;
    i_tag     = 8'(tag);
    i_valid   = 1'b1;
  endtask

  function automatic int rnd_coef();
    return int'($urandom_range(0, 2 * BFU_Q - 2)) - (QS - 1);
  endfunction

  initial begin
    i_rst = 1'b1; i_stall = 1'b0; i_valid = 1'b0;
    i_mode = 2'b00; i_a = '0; i_b = '0; i_twiddle = '0; i_tag = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_valid", o_valid, 0);
    chk("reset_a", o_a, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // NTT with Montgomery one: latency exactly 5
    drive(0, 10, 5, int'(BFU_MONT), 1);
    @(negedge i_clk); i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("ntt_early", o_valid, 0);
    @(negedge i_clk);
    chk("ntt_valid", o_valid, 1);
    chk("ntt_a", o_a, 15);
    chk("ntt_b", o_b, 5);
    chk("ntt_tag", o_tag, 1);

    // INTT then NTT with zero twiddle, back to back
    drive(1, 3, 10, int'(BFU_MONT), 2);
    @(negedge i_clk);
    drive(0, 100, 7, 0, 3);
    @(negedge i_clk); i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("intt_a", o_a, 13);
    chk("intt_b", o_b, 7);
    @(negedge i_clk);
    chk("tw0_a", o_a, 100);
    chk("tw0_b", o_b, 100);

    // Skip passes values through exactly
    drive(2, -123, 8380416, int'($urandom), 4);
    @(negedge i_clk); i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("skip_valid", o_valid, 1);
    chk("skip_a", o_a, -123);
    chk("skip_b", o_b, 8380416);

    // Negative difference: corrected into [0,Q) only with the macro
    drive(0, 0, 5, int'(BFU_MONT), 5);
    @(negedge i_clk); i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("corr_a", o_a, 5);
`ifdef BFU_CORRECT_EN
    chk("corr_b", o_b, 8380412);
`else
    chk("corr_b", o_b, -5);
`endif

    // Stall for 3 cycles with 2 ops in flight; total latency becomes 8
    drive(0, 10, 5, int'(BFU_MONT), 6);
    @(negedge i_clk);
    drive(1, 3, 10, int'(BFU_MONT), 7);
    @(negedge i_clk);
    i_stall = 1'b1;
    drive(2, 1, 2, 3, 99);
    repeat (3) @(negedge i_clk);
    i_stall = 1'b0; i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("stall_early", o_valid, 0);
    @(negedge i_clk);
    chk("stall_valid", o_valid, 1);
    chk("stall_a", o_a, 15);
    chk("stall_tag", o_tag, 6);
    @(negedge i_clk);
    chk("stall2_a", o_a, 13);
    chk("stall2_tag", o_tag, 7);
    @(negedge i_clk);
    chk("stall_drop", o_valid, 0);

    // 64 back-to-back mixed-mode ops, tags 0..63
    for (int i = 0; i < 64; i++) begin
      drive(int'($urandom_range(0, 3)), rnd_coef(), rnd_coef(), rnd_coef(), i);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    repeat (8) @(negedge i_clk);

    // Random stalls and gaps
    for (int i = 0; i < 200; i++) begin
      drive(int'($urandom_range(0, 3)), rnd_coef(), rnd_coef(), rnd_coef(), i);
      i_valid = ($urandom_range(0, 3) != 0);
      i_stall = ($urandom_range(0, 3) == 0);
      @(negedge i_clk);
    end
    i_stall = 1'b0; i_valid = 1'b0;
    repeat (8) @(negedge i_clk);

    // Reset with one result at the output and 4 ops in flight
    for (int i = 0; i < 5; i++) begin
      drive(0, 10 + i, 5, int'(BFU_MONT), 200 + i);
      @(negedge i_clk);
    end
    i_valid = 1'b0;
    chk("pre_rst_valid", o_valid, 1);
    chk("pre_rst_a", o_a, 15);
    i_rst = 1'b1;
    #1;
    chk("rst_now_valid", o_valid, 0);
    chk("rst_now_a", o_a, 0);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge i_clk);
      chk("post_rst_idle", o_valid, 0);
    end
    drive(1, 3, 10, int'(BFU_MONT), 42);
    @(negedge i_clk); i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("post_rst_valid", o_valid, 1);
    chk("post_rst_a", o_a, 13);
    chk("post_rst_tag", o_tag, 42);
    repeat (2) @(negedge i_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
